// File: rtl/blackjack_pkg.sv
// rtl/blackjack_pkg.sv - shared deck constants and shuffler state encoding
package blackjack_pkg;

  localparam int DECK_SIZE = 52;
  localparam int ADDR_W    = 6;

  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t DECK_N    = addr_t'(DECK_SIZE);
  localparam addr_t DECK_LAST = addr_t'(DECK_SIZE - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_SWAP  = 3'd3;
  localparam logic [2:0] S_READY = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = S_IDLE,
    INIT  = S_INIT,
    FETCH = S_FETCH,
    SWAP  = S_SWAP,
    READY = S_READY
  } state_e;

endpackage

// File: rtl/deck_regfile.sv
// rtl/deck_regfile.sv - deck storage with one async read port and a dual-write swap port
module deck_regfile
  import blackjack_pkg::*;
(
  input  logic              clk_i,
  input  logic              we_init_i,
  input  logic              we_swap_i,
  input  logic [ADDR_W-1:0] addr_a_i,
  input  logic [ADDR_W-1:0] addr_b_i,
  input  logic [ADDR_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [ADDR_W-1:0] rd_data_o
);

  logic [ADDR_W-1:0] mem_q [DECK_SIZE];

  // Both swap writes read the pre-edge contents, so a==b is a harmless no-op.
  always_ff @(posedge clk_i) begin
    if (we_swap_i) begin
      mem_q[addr_a_i] <= mem_q[addr_b_i];
      mem_q[addr_b_i] <= mem_q[addr_a_i];
    end else if (we_init_i) begin
      mem_q[addr_a_i] <= wdata_i;
    end
  end

  assign rd_data_o = (rd_addr_i < DECK_N) ? mem_q[rd_addr_i] : '0;

endmodule

// File: rtl/deck_shuffler.sv
// rtl/deck_shuffler.sv - shuffle FSM driving Nxt_Addr and dealing cards from the deck
module deck_shuffler
  import blackjack_pkg::*;
(
  input  logic              clk_2K,
  input  logic              i_Reset,
  input  logic              i_Shuffle,
  output logic [ADDR_W-1:0] o_Addr_i,
  input  logic [ADDR_W-1:0] i_Addr_j,
  input  logic              i_DealReq,
  output logic [ADDR_W-1:0] o_Card,
  output logic              o_CardValid,
  output logic              o_Busy,
  output logic              o_Done,
  output logic              o_Empty
);

  state_e state_q;
  addr_t  k_q;
  addr_t  idx_q;
  addr_t  j_q;
  addr_t  top_q;
  addr_t  card_q;
  logic   cvalid_q;
  logic   busy_q;
  logic   done_q;
  logic   empty_q;

  logic   we_init;
  logic   we_swap;
  addr_t  addr_a;
  addr_t  rd_data;

  // Writes are suppressed on reset/abort edges; INIT rewrites the deck anyway.
  assign we_init = (state_q == INIT) && !i_Reset && !i_Shuffle;
  assign we_swap = (state_q == SWAP) && !i_Reset && !i_Shuffle;
  assign addr_a  = (state_q == INIT) ? k_q : idx_q;

  deck_regfile u_regfile (
    .clk_i     (clk_2K),
    .we_init_i (we_init),
    .we_swap_i (we_swap),
    .addr_a_i  (addr_a),
    .addr_b_i  (j_q),
    .wdata_i   (k_q),
    .rd_addr_i (top_q),
    .rd_data_o (rd_data)
  );

  always_ff @(posedge clk_2K) begin
    if (i_Reset) begin
      state_q  <= IDLE;
      k_q      <= '0;
      idx_q    <= '0;
      j_q      <= '0;
      top_q    <= '0;
      card_q   <= '0;
      cvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      cvalid_q <= 1'b0;
      done_q   <= 1'b0;
      if (i_Shuffle) begin
        state_q <= INIT;
        k_q     <= '0;
        idx_q   <= '0;
        top_q   <= '0;
        empty_q <= 1'b1;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          IDLE: ;
          INIT: begin
            k_q <= k_q + addr_t'(1);
            if (k_q == DECK_LAST) begin
              state_q <= FETCH;
              idx_q   <= '0;
            end
          end
          FETCH: begin
            // Out-of-range partner degrades to a self-swap instead of corrupting the deck.
            j_q     <= (i_Addr_j >= DECK_N) ? idx_q : i_Addr_j;
            state_q <= SWAP;
          end
          SWAP: begin
            if (idx_q == DECK_LAST) begin
              state_q <= READY;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              top_q   <= '0;
              empty_q <= 1'b0;
            end else begin
              idx_q   <= idx_q + addr_t'(1);
              state_q <= FETCH;
            end
          end
          READY: begin
            if (i_DealReq && (top_q < DECK_N)) begin
              card_q   <= rd_data;
              cvalid_q <= 1'b1;
              top_q    <= top_q + addr_t'(1);
              if (top_q == DECK_LAST) empty_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign o_Addr_i    = idx_q;
  assign o_Card      = card_q;
  assign o_CardValid = cvalid_q;
  assign o_Busy      = busy_q;
  assign o_Done      = done_q;
  assign o_Empty     = empty_q;

endmodule

// File: tb/tb_deck_shuffler.sv
// tb/tb_deck_shuffler.sv - scoreboard bench for deck_shuffler with Nxt_Addr stubs
`timescale 1us/1ns
module tb_deck_shuffler;

  localparam int MODE_ID   = 0;
  localparam int MODE_REAL = 1;
  localparam int MODE_OOR  = 2;

  logic       clk_2K = 1'b0;
  logic       i_Reset = 1'b1;
  logic       i_Shuffle = 1'b0;
  logic       i_DealReq = 1'b0;
  logic [5:0] o_Addr_i;
  logic [5:0] i_Addr_j;
  logic [5:0] o_Card;
  logic       o_CardValid, o_Busy, o_Done, o_Empty;

  logic [5:0] cnt = '0;
  int         stub_mode = MODE_ID;
  int         n_checks = 0;
  int         n_fail = 0;
  int         exp_deck [52];
  int         model_top = 0;
  int         sb [$];
  int         dealt [$];

  deck_shuffler dut (
    .clk_2K      (clk_2K),
    .i_Reset     (i_Reset),
    .i_Shuffle   (i_Shuffle),
    .o_Addr_i    (o_Addr_i),
    .i_Addr_j    (i_Addr_j),
    .i_DealReq   (i_DealReq),
    .o_Card      (o_Card),
    .o_CardValid (o_CardValid),
    .o_Busy      (o_Busy),
    .o_Done      (o_Done),
    .o_Empty     (o_Empty)
  );

  always #250 clk_2K = ~clk_2K;

  // Free-running counter standing in for the Nxt_Addr Counter.
  always @(posedge clk_2K) cnt <= cnt + 6'd1;

  always_comb begin
    i_Addr_j = 6'd63;
    case (stub_mode)
      MODE_ID:   i_Addr_j = o_Addr_i;
      MODE_REAL: i_Addr_j = o_Addr_i + cnt;
      default:   i_Addr_j = 6'd63;
    endcase
  end

  always @(negedge clk_2K) begin
    if (o_CardValid === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid: got card %0d, required no o_CardValid", o_Card);
      end else begin
        int e;
        e = sb.pop_front();
        if (o_Card !== 6'(e)) begin
          n_fail++;
          $display("FAIL card: got %0d, required %0d", o_Card, e);
        end
      end
      dealt.push_back(int'(o_Card));
    end
  end

  // Deck after a shuffle whose sampling edge E0 saw counter value c.
  task automatic model_shuffle(input int c, input int mode);
    int j, cn, t;
    for (int k = 0; k < 52; k++) exp_deck[k] = k;
    for (int i = 0; i < 52; i++) begin
      cn = (c + 53 + 2 * i) % 64;
      if (mode == MODE_ID) j = i;
      else if (mode == MODE_REAL) j = (i + cn) % 64;
      else j = 63;
      if (j >= 52) j = i;
      t = exp_deck[i];
      exp_deck[i] = exp_deck[j];
      exp_deck[j] = t;
    end
  endtask

  task automatic shuffle_and_wait(input int mode, input bit with_deal);
    int done_at, done_cnt;
    @(negedge clk_2K);
    stub_mode = mode;
    model_shuffle(int'(cnt), mode);
    model_top = 0;
    i_Shuffle = 1'b1;
    i_DealReq = with_deal;
    @(negedge clk_2K);
    i_Shuffle = 1'b0;
    i_DealReq = 1'b0;
    n_checks++;
    if (o_Busy !== 1'b1 || o_Empty !== 1'b1 || o_CardValid !== 1'b0 || o_Done !== 1'b0) begin
      n_fail++;
      $display("FAIL start_state: got busy=%b empty=%b valid=%b done=%b, required 1 1 0 0",
               o_Busy, o_Empty, o_CardValid, o_Done);
    end
    done_at = 0;
    done_cnt = 0;
    for (int c = 2; c <= 220; c++) begin
      @(negedge clk_2K);
      if (o_Done === 1'b1) begin
        done_cnt++;
        if (done_at == 0) done_at = c;
      end
      if (c == 156) begin
        n_checks++;
        if (o_Busy !== 1'b1) begin
          n_fail++;
          $display("FAIL busy_last_swap: got %b, required 1", o_Busy);
        end
      end
      if (c == 157) begin
        n_checks++;
        if (o_Busy !== 1'b0 || o_Empty !== 1'b0) begin
          n_fail++;
          $display("FAIL ready_flags: got busy=%b empty=%b, required 0 0", o_Busy, o_Empty);
        end
      end
    end
    n_checks++;
    if (done_at != 157 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL done_timing: got first at cycle %0d count %0d, required cycle 157 count 1",
               done_at, done_cnt);
    end
  endtask

  task automatic deal_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_2K);
      i_DealReq = 1'b1;
      if (model_top < 52) begin
        sb.push_back(exp_deck[model_top]);
        model_top++;
      end
    end
    @(negedge clk_2K);
    i_DealReq = 1'b0;
    @(negedge clk_2K);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL missing_deals: got %0d undelivered, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    i_Reset = 1'b1;
    repeat (3) @(negedge clk_2K);
    n_checks++;
    if (o_Addr_i !== 6'd0 || o_Card !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_data: got addr=%0d card=%0d, required 0 0", o_Addr_i, o_Card);
    end
    n_checks++;
    if (o_CardValid !== 1'b0 || o_Busy !== 1'b0 || o_Done !== 1'b0 || o_Empty !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_flags: got valid=%b busy=%b done=%b empty=%b, required 0 0 0 1",
               o_CardValid, o_Busy, o_Done, o_Empty);
    end
    i_Reset = 1'b0;
    @(negedge clk_2K);
    i_Shuffle = 1'b1;
    @(negedge clk_2K);
    i_Shuffle = 1'b0;
    repeat (59) @(negedge clk_2K);
    i_Reset = 1'b1;
    @(negedge clk_2K);
    i_Reset = 1'b0;
    n_checks++;
    if (o_Addr_i !== 6'd0 || o_Busy !== 1'b0 || o_Empty !== 1'b1 || o_Done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_swap: got addr=%0d busy=%b empty=%b done=%b, required 0 0 1 0",
               o_Addr_i, o_Busy, o_Empty, o_Done);
    end
    repeat (3) @(negedge clk_2K);
    n_checks++;
    if (o_Busy !== 1'b0 || o_Empty !== 1'b1 || o_Addr_i !== 6'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b empty=%b addr=%0d, required 0 1 0",
               o_Busy, o_Empty, o_Addr_i);
    end
  endtask

  task automatic test_identity();
    shuffle_and_wait(MODE_ID, 1'b0);
    deal_n(52);
    n_checks++;
    if (o_Empty !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_after_52: got %b, required 1", o_Empty);
    end
  endtask

  task automatic test_real();
    bit seen [52];
    int dup;
    shuffle_and_wait(MODE_REAL, 1'b0);
    dealt.delete();
    deal_n(52);
    dup = 0;
    for (int k = 0; k < 52; k++) seen[k] = 1'b0;
    foreach (dealt[i]) begin
      if (dealt[i] > 51 || seen[dealt[i]]) dup++;
      else seen[dealt[i]] = 1'b1;
    end
    n_checks++;
    if (dealt.size() != 52 || dup != 0) begin
      n_fail++;
      $display("FAIL permutation: got %0d cards %0d repeats, required 52 cards 0 repeats",
               dealt.size(), dup);
    end
    n_checks++;
    if (o_Empty !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_real: got %b, required 1", o_Empty);
    end
    @(negedge clk_2K);
    i_DealReq = 1'b1;
    @(negedge clk_2K);
    i_DealReq = 1'b0;
    n_checks++;
    if (o_CardValid !== 1'b0 || o_Empty !== 1'b1) begin
      n_fail++;
      $display("FAIL deal_53: got valid=%b empty=%b, required 0 1", o_CardValid, o_Empty);
    end
  endtask

  task automatic test_out_of_range();
    shuffle_and_wait(MODE_OOR, 1'b0);
    deal_n(52);
  endtask

  task automatic test_abort();
    shuffle_and_wait(MODE_REAL, 1'b0);
    deal_n(10);
    shuffle_and_wait(MODE_REAL, 1'b0);
    deal_n(5);
  endtask

  task automatic test_collision();
    shuffle_and_wait(MODE_ID, 1'b1);
    deal_n(3);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_real();
    test_out_of_range();
    test_abort();
    test_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
